// File: rtl/sdram_burst_arb_if.sv
// Burst-request bus between the SDRAM burst arbiter (master) and the FIFO/SDRAM-core side (slave).
interface sdram_burst_arb_if;
  logic        sdram_init_done;
  logic [9:0]  wrfifo_usedw;
  logic [9:0]  rdfifo_usedw;
  logic        rd_en;
  logic        addr_clr;
  logic        sdram_wr_ack;
  logic        sdram_rd_ack;
  logic        sdram_wr_req;
  logic        sdram_rd_req;
  logic [23:0] sys_wraddr;
  logic [23:0] sys_rdaddr;
  logic [9:0]  sdwr_byte;
  logic [9:0]  sdrd_byte;
  logic        wr_wrap;
  logic        rd_wrap;
  logic        busy;

  modport master (
    input  sdram_init_done, wrfifo_usedw, rdfifo_usedw, rd_en, addr_clr,
    input  sdram_wr_ack, sdram_rd_ack,
    output sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr, sdwr_byte, sdrd_byte,
    output wr_wrap, rd_wrap, busy
  );

  modport slave (
    output sdram_init_done, wrfifo_usedw, rdfifo_usedw, rd_en, addr_clr,
    output sdram_wr_ack, sdram_rd_ack,
    input  sdram_wr_req, sdram_rd_req, sys_wraddr, sys_rdaddr, sdwr_byte, sdrd_byte,
    input  wr_wrap, rd_wrap, busy
  );
endinterface

// File: rtl/sdram_burst_arb.sv
// Decides when to issue SDRAM write/read bursts from FIFO fill levels, generates burst
// addresses with region wrap, and runs a single-outstanding req/ack handshake.
module sdram_burst_arb #(
  parameter int unsigned BURST_LEN = 256,
  parameter logic [23:0] WR_BASE   = 24'h000000,
  parameter logic [23:0] WR_END    = 24'h0FFFFF,
  parameter logic [23:0] RD_BASE   = 24'h000000,
  parameter logic [23:0] RD_END    = 24'h0FFFFF,
  parameter int unsigned RD_THRESH = 256
) (
  input logic               clk,
  input logic               rst_n,
  sdram_burst_arb_if.master bus
);

  localparam logic [9:0]  BurstLen10 = BURST_LEN[9:0];
  localparam logic [24:0] BurstLen25 = BURST_LEN[24:0];

  typedef enum logic [2:0] {StIdle, StWrReq, StWrBurst, StRdReq, StRdBurst} state_e;

  state_e      state_q;
  logic        wr_req_q, rd_req_q, busy_q;
  logic        wr_wrap_q, rd_wrap_q;
  logic [23:0] wr_addr_q, rd_addr_q;
  logic        wr_ack_q, rd_ack_q;
  logic        last_wr_q;
  logic        clr_pend_q;

  logic        wr_ok, rd_ok, wr_fall, rd_fall, clr_now, wr_over, rd_over;
  logic [24:0] wr_sum, rd_sum;

  always_comb begin
    wr_ok   = bus.sdram_init_done && (32'(bus.wrfifo_usedw) >= BURST_LEN);
    rd_ok   = bus.sdram_init_done && bus.rd_en && (32'(bus.rdfifo_usedw) < RD_THRESH);
    wr_fall = wr_ack_q && !bus.sdram_wr_ack;
    rd_fall = rd_ack_q && !bus.sdram_rd_ack;
    clr_now = clr_pend_q || bus.addr_clr;
    // 25-bit sums so a region ending near the top of the address space cannot overflow
    wr_sum  = {1'b0, wr_addr_q} + BurstLen25;
    rd_sum  = {1'b0, rd_addr_q} + BurstLen25;
    wr_over = wr_sum > {1'b0, WR_END};
    rd_over = rd_sum > {1'b0, RD_END};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_wrap_q  <= 1'b0;
      rd_wrap_q  <= 1'b0;
      wr_addr_q  <= WR_BASE;
      rd_addr_q  <= RD_BASE;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      last_wr_q  <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      wr_ack_q  <= bus.sdram_wr_ack;
      rd_ack_q  <= bus.sdram_rd_ack;
      wr_wrap_q <= 1'b0;
      rd_wrap_q <= 1'b0;
      if (state_q != StIdle && bus.addr_clr) clr_pend_q <= 1'b1;

      case (state_q)
        StIdle: begin
          if (bus.addr_clr) begin
            wr_addr_q <= WR_BASE;
            rd_addr_q <= RD_BASE;
          end
          // On a tie, grant the side that did not win last time
          if (wr_ok && (!rd_ok || !last_wr_q)) begin
            state_q   <= StWrReq;
            wr_req_q  <= 1'b1;
            busy_q    <= 1'b1;
            last_wr_q <= 1'b1;
          end else if (rd_ok) begin
            state_q   <= StRdReq;
            rd_req_q  <= 1'b1;
            busy_q    <= 1'b1;
            last_wr_q <= 1'b0;
          end
        end
        StWrReq: begin
          if (bus.sdram_wr_ack) begin
            wr_req_q <= 1'b0;
            state_q  <= StWrBurst;
          end
        end
        StWrBurst: begin
          if (wr_fall) begin
            if (clr_now) begin
              wr_addr_q <= WR_BASE;
              rd_addr_q <= RD_BASE;
            end else if (wr_over) begin
              wr_addr_q <= WR_BASE;
              wr_wrap_q <= 1'b1;
            end else begin
              wr_addr_q <= wr_sum[23:0];
            end
            clr_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end
        end
        StRdReq: begin
          if (bus.sdram_rd_ack) begin
            rd_req_q <= 1'b0;
            state_q  <= StRdBurst;
          end
        end
        StRdBurst: begin
          if (rd_fall) begin
            if (clr_now) begin
              wr_addr_q <= WR_BASE;
              rd_addr_q <= RD_BASE;
            end else if (rd_over) begin
              rd_addr_q <= RD_BASE;
              rd_wrap_q <= 1'b1;
            end else begin
              rd_addr_q <= rd_sum[23:0];
            end
            clr_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end
        end
        default: begin
          state_q  <= StIdle;
          wr_req_q <= 1'b0;
          rd_req_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sdram_wr_req = wr_req_q;
  assign bus.sdram_rd_req = rd_req_q;
  assign bus.sys_wraddr   = wr_addr_q;
  assign bus.sys_rdaddr   = rd_addr_q;
  assign bus.sdwr_byte    = BurstLen10;
  assign bus.sdrd_byte    = BurstLen10;
  assign bus.wr_wrap      = wr_wrap_q;
  assign bus.rd_wrap      = rd_wrap_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_sdram_burst_arb.sv
// Bench for sdram_burst_arb: boundary vector table, hand-written corner sequences and
// randomized bursts checked against a burst-level arbitration/address model.
module tb_sdram_burst_arb;
  localparam int unsigned BL = 256;
  localparam logic [23:0] WB = 24'h000000;
  localparam logic [23:0] WE = 24'h0002FF;
  localparam logic [23:0] RB = 24'h000400;
  localparam logic [23:0] RE = 24'h0005FF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_burst_arb_if bus();

  sdram_burst_arb #(
    .BURST_LEN(BL), .WR_BASE(WB), .WR_END(WE), .RD_BASE(RB), .RD_END(RE), .RD_THRESH(256)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Burst-level model state
  logic [23:0] m_wr, m_rd;
  bit          m_last_w;

  typedef struct {
    bit          init;
    int          wr;
    int          rd;
    bit          en;
    int          g;     // 0 none, 1 write, 2 read
    logic [23:0] addr;
    bit          wrap;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit init, input int wr, input int rd, input bit en);
    bus.sdram_init_done = init;
    bus.wrfifo_usedw    = 10'(wr);
    bus.rdfifo_usedw    = 10'(rd);
    bus.rd_en           = en;
  endtask

  function automatic int predict(input bit init, input int wr, input int rd, input bit en);
    bit w_ok, r_ok;
    w_ok = init && (wr >= 256);
    r_ok = init && en && (rd < 256);
    if (w_ok && r_ok) return m_last_w ? 2 : 1;
    if (w_ok) return 1;
    if (r_ok) return 2;
    return 0;
  endfunction

  task automatic model_burst(input int g, input bit clr, output bit wrap);
    wrap = 1'b0;
    if (g != 0) m_last_w = (g == 1);
    if (g == 0) return;
    if (clr) begin
      m_wr = WB;
      m_rd = RB;
    end else if (g == 1) begin
      if (32'(m_wr) + BL > 32'(WE)) begin m_wr = WB; wrap = 1'b1; end
      else m_wr = m_wr + 24'(BL);
    end else begin
      if (32'(m_rd) + BL > 32'(RE)) begin m_rd = RB; wrap = 1'b1; end
      else m_rd = m_rd + 24'(BL);
    end
  endtask

  task automatic set_ack(input int g, input bit v);
    if (g == 1) bus.sdram_wr_ack = v;
    else if (g == 2) bus.sdram_rd_ack = v;
  endtask

  // Called at a negedge with inputs already driven and the DUT idle.
  // mid: 1 = addr_clr pulse during the burst, 2 = drop init_done during the burst.
  task automatic run_txn(input string tag, input int g, input logic [23:0] exp_addr,
                         input bit exp_wrap, input int mid, input bit wrong_ack,
                         input int ack_len, input int ack_delay);
    int got;
    got = 0;
    if (g == 0) begin
      repeat (4) @(negedge clk);
      chk({tag, "_no_grant"}, {bus.sdram_wr_req, bus.sdram_rd_req, bus.busy}, 0);
      return;
    end
    for (int i = 0; i < 2 && got == 0; i++) begin
      @(negedge clk);
      if (bus.sdram_wr_req) got = 1;
      else if (bus.sdram_rd_req) got = 2;
    end
    chk({tag, "_grant"}, got, g);
    if (got == 0) return;
    chk({tag, "_addr"}, (got == 1) ? bus.sys_wraddr : bus.sys_rdaddr, exp_addr);
    chk({tag, "_len"}, (got == 1) ? bus.sdwr_byte : bus.sdrd_byte, BL);
    chk({tag, "_busy"}, bus.busy, 1);
    for (int i = 0; i < ack_delay; i++) begin
      if (wrong_ack) set_ack(3 - got, 1'b1);
      @(negedge clk);
    end
    set_ack(3 - got, 1'b0);
    if (ack_delay > 0)
      chk({tag, "_req_hold"}, (got == 1) ? bus.sdram_wr_req : bus.sdram_rd_req, 1);
    set_ack(got, 1'b1);
    @(negedge clk);
    chk({tag, "_req_drop"}, {bus.sdram_wr_req, bus.sdram_rd_req, bus.busy}, 3'b001);
    for (int i = 1; i < ack_len; i++) begin
      if (i == 1 && mid == 1) bus.addr_clr = 1'b1;
      if (i == 1 && mid == 2) bus.sdram_init_done = 1'b0;
      @(negedge clk);
      bus.addr_clr = 1'b0;
    end
    chk({tag, "_addr_hold"}, (got == 1) ? bus.sys_wraddr : bus.sys_rdaddr, exp_addr);
    set_ack(got, 1'b0);
    @(negedge clk);
    chk({tag, "_end"}, {bus.sdram_wr_req, bus.sdram_rd_req, bus.busy}, 0);
    chk({tag, "_wrap"}, {bus.wr_wrap, bus.rd_wrap},
        {(got == 1) && exp_wrap, (got == 2) && exp_wrap});
  endtask

  // Drive inputs, derive expectations from the model, run one transaction, compare pointers.
  task automatic txn_model(input string tag, input bit init, input int wr, input int rd,
                           input bit en, input int mid, input bit wrong_ack, input int len,
                           input int dly);
    int          g, m;
    bit          wrap;
    logic [23:0] ea;
    m = (len < 2 && mid == 1) ? 0 : mid;
    drive(init, wr, rd, en);
    g  = predict(init, wr, rd, en);
    ea = (g == 1) ? m_wr : m_rd;
    model_burst(g, m == 1, wrap);
    run_txn(tag, g, ea, wrap, m, wrong_ack, len, dly);
    chk({tag, "_wrptr"}, bus.sys_wraddr, m_wr);
    chk({tag, "_rdptr"}, bus.sys_rdaddr, m_rd);
  endtask

  function automatic int pick_level();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 255;
    if (r == 1) return 256;
    return $urandom_range(0, 1023);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit wrap_unused;
    int seen;
    vecs[0] = '{1'b1, 256,  300, 1'b1, 1, 24'h000000, 1'b0};
    vecs[1] = '{1'b1, 255,  255, 1'b1, 2, 24'h000400, 1'b0};
    vecs[2] = '{1'b1, 300,  10,  1'b1, 1, 24'h000100, 1'b0};
    vecs[3] = '{1'b1, 300,  10,  1'b1, 2, 24'h000500, 1'b1};
    vecs[4] = '{1'b0, 512,  0,   1'b1, 0, 24'h000000, 1'b0};
    vecs[5] = '{1'b1, 100,  0,   1'b0, 0, 24'h000000, 1'b0};
    vecs[6] = '{1'b1, 1023, 256, 1'b1, 1, 24'h000200, 1'b1};
    vecs[7] = '{1'b1, 1023, 0,   1'b1, 2, 24'h000400, 1'b0};
    vecs[8] = '{1'b1, 255,  256, 1'b1, 0, 24'h000000, 1'b0};

    drive(1'b0, 0, 0, 1'b0);
    bus.addr_clr = 1'b0;
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    m_wr = WB;
    m_rd = RB;
    m_last_w = 1'b0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", {bus.sdram_wr_req, bus.sdram_rd_req}, 0);
    chk("rst_busy_wrap", {bus.busy, bus.wr_wrap, bus.rd_wrap}, 0);
    chk("rst_wraddr", bus.sys_wraddr, WB);
    chk("rst_rdaddr", bus.sys_rdaddr, RB);
    chk("rst_bytes", {bus.sdwr_byte, bus.sdrd_byte}, {10'd256, 10'd256});
    rst_n = 1'b1;

    // Boundary table, applied in order from reset (round-robin history is part of it)
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].init, vecs[i].wr, vecs[i].rd, vecs[i].en);
      model_burst(vecs[i].g, 1'b0, wrap_unused);
      run_txn($sformatf("vec%0d", i), vecs[i].g, vecs[i].addr, vecs[i].wrap, 0, 1'b0, 3, i % 3);
    end
    chk("vec_wrptr", bus.sys_wraddr, m_wr);
    chk("vec_rdptr", bus.sys_rdaddr, m_rd);

    // init_done low holds off requests, raising it grants within two cycles
    drive(1'b0, 512, 0, 1'b0);
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.sdram_wr_req || bus.sdram_rd_req || bus.busy) seen++;
    end
    chk("init_hold_cycles", seen, 0);
    txn_model("init_rise", 1'b1, 512, 0, 1'b0, 0, 1'b0, 256, 0);

    // Ack on the wrong channel is ignored while requesting
    txn_model("wrong_ack_w", 1'b1, 512, 300, 1'b1, 0, 1'b1, 4, 3);
    txn_model("wrong_ack_r", 1'b1, 0, 5, 1'b1, 0, 1'b1, 4, 3);

    // addr_clr while idle reloads both pointers without a wrap pulse
    txn_model("pre_clr_w", 1'b1, 400, 0, 1'b0, 0, 1'b0, 2, 0);
    txn_model("pre_clr_r", 1'b1, 0, 0, 1'b1, 0, 1'b0, 2, 0);
    drive(1'b1, 0, 300, 1'b1);
    bus.addr_clr = 1'b1;
    @(negedge clk);
    bus.addr_clr = 1'b0;
    m_wr = WB;
    m_rd = RB;
    chk("idle_clr_ptrs", {bus.sys_wraddr, bus.sys_rdaddr}, {WB, RB});
    chk("idle_clr_wrap", {bus.wr_wrap, bus.rd_wrap, bus.busy}, 0);

    // addr_clr during a burst is applied at its ack fall, to both pointers
    txn_model("mid_w1", 1'b1, 500, 0, 1'b0, 0, 1'b0, 2, 0);
    txn_model("mid_r1", 1'b1, 0, 0, 1'b1, 0, 1'b0, 2, 0);
    txn_model("mid_clr", 1'b1, 500, 0, 1'b0, 1, 1'b0, 5, 1);
    txn_model("after_clr", 1'b1, 500, 0, 1'b0, 0, 1'b0, 2, 0);

    // init_done dropping mid-burst: burst completes, no further grants
    txn_model("init_drop", 1'b1, 600, 0, 1'b0, 2, 1'b0, 4, 0);
    run_txn("init_drop_after", 0, 24'h0, 1'b0, 0, 1'b0, 1, 0);

    // Randomized bursts
    for (int k = 0; k < 60; k++) begin
      txn_model($sformatf("rnd%0d", k), ($urandom_range(0, 7) != 0), pick_level(),
                pick_level(), $urandom_range(0, 1) == 1, ($urandom_range(0, 4) == 0) ? 1 : 0,
                $urandom_range(0, 5) == 0, $urandom_range(1, 12), $urandom_range(0, 3));
    end

    // Reset during a write burst with ack high
    drive(1'b1, 512, 0, 1'b0);
    seen = 0;
    for (int i = 0; i < 3 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.sdram_wr_req) seen = 1;
    end
    chk("rst_mid_grant", seen, 1);
    bus.sdram_wr_ack = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_busy", {bus.sdram_wr_req, bus.sdram_rd_req, bus.busy}, 0);
    chk("rst_mid_ptrs", {bus.sys_wraddr, bus.sys_rdaddr}, {WB, RB});
    bus.sdram_wr_ack = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sdram_burst_arb.md
Name: sdram_burst_arb

Overview:
Upstream stage of the SDRAM top-level. It watches the fill levels of an external write FIFO and an external read FIFO, and decides when to issue a burst write or burst read request. It generates the burst addresses and lengths, and runs the req/ack handshake. One request is outstanding at a time; the SDRAM core's ack high period delimits each burst.

Parameters:
BURST_LEN, 256, words per burst; drives sdwr_byte/sdrd_byte (1..256)
WR_BASE, 24'h000000, first write address
WR_END, 24'h0FFFFF, last word of write region (inclusive)
RD_BASE, 24'h000000, first read address
RD_END, 24'h0FFFFF, last word of read region (inclusive)
RD_THRESH, 256, read FIFO level below which a read burst is wanted

Ports:
clk  in  1  system clock, 100 MHz; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
sdram_init_done  in  1  SDRAM init complete; no requests while low
wrfifo_usedw  in  10  words held in write FIFO
rdfifo_usedw  in  10  words held in read FIFO
rd_en  in  1  read path enable; read bursts only when high
addr_clr  in  1  one-cycle pulse; restart both address pointers at base
sdram_wr_ack  in  1  high for the duration of a write burst
sdram_rd_ack  in  1  high for the duration of a read burst
sdram_wr_req  out  1  write burst request
sdram_rd_req  out  1  read burst request
sys_wraddr  out  24  write burst start address
sys_rdaddr  out  24  read burst start address
sdwr_byte  out  10  write burst length = BURST_LEN
sdrd_byte  out  10  read burst length = BURST_LEN
wr_wrap  out  1  one-cycle pulse when write pointer wraps
rd_wrap  out  1  one-cycle pulse when read pointer wraps
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (rst_n low at an edge):
  - state=IDLE; both req=0; sys_wraddr=WR_BASE; sys_rdaddr=RD_BASE.
  - wr_wrap=0, rd_wrap=0, busy=0; last_grant=READ, so write wins the first tie.
- Reset mid-burst drops req immediately. No ack cleanup: the core is reset from the same rst_n.
- sdwr_byte and sdrd_byte are constant BURST_LEN; width-truncated to 10 bits.
- Eligibility (evaluated in IDLE only):
  - wr_ok = init_done & (wrfifo_usedw >= BURST_LEN).
  - rd_ok = init_done & rd_en & (rdfifo_usedw < RD_THRESH).
- States:
  - IDLE:
    - only wr_ok -> WR_REQ; only rd_ok -> RD_REQ.
    - both -> the opposite of last_grant (round-robin).
    - neither -> stay.
    - last_grant updates on the grant.
  - WR_REQ: sdram_wr_req=1 (registered; rises the cycle after the IDLE decision). When sdram_wr_ack=1 is sampled: req=0 next cycle, -> WR_BURST.
  - WR_BURST: wait for ack falling edge (ack_d=1, ack=0). On that edge:
    - sys_wraddr += BURST_LEN.
    - If old addr + BURST_LEN > WR_END, load WR_BASE instead and pulse wr_wrap for 1 cycle.
    - -> IDLE.
  - RD_REQ / RD_BURST: identical, using rd signals and the RD_* parameters.
- Minimum turnaround: ack fall -> IDLE (1 cycle) -> next req asserted the following cycle.
- sys_wraddr/sys_rdaddr are stable from req assertion until the ack falling edge.
- addr_clr:
  - In IDLE: both pointers reload base at the next edge; no wrap pulse.
  - While busy: latched; applied on the current burst's ack falling edge instead of the increment. It also applies to the idle pointer at that same edge.
- sdram_init_done dropping while busy: the current handshake completes; no new grants afterwards.
- Ack seen in the wrong state (e.g. rd_ack in WR_REQ) is ignored.
- No timeout; the req stays high until ack arrives.

Test Plan:
- Reset, init_done=1, wrfifo_usedw=256, rd_en=0 -> wr_req high 1 cycle after IDLE eval; sys_wraddr=0x000000, sdwr_byte=256. Ack high 256 cycles then low -> sys_wraddr=0x000100, busy drops.
- wrfifo_usedw=300, rdfifo_usedw=10, rd_en=1, both continuously eligible -> grants alternate W,R,W,R. sys_rdaddr sequence 0x000000, 0x000100.
- WR_END=0x0002FF, four write bursts -> addresses 0x000000, 0x000100, 0x000200, 0x000000. wr_wrap pulses exactly once, after the third burst.
- addr_clr pulsed mid write burst at sys_wraddr=0x000300 -> after ack fall both pointers = base, no wr_wrap; next write uses 0x000000.
- init_done=0 with wrfifo_usedw=512 -> no req for 1000 cycles. Raise init_done -> wr_req within 2 cycles.
- rst_n low during WR_BURST (ack high) -> next edge: req=0, busy=0, sys_wraddr=WR_BASE.
